// File: rtl/flag_register_unit.sv
// Architectural flag register fed by the EX-stage ALU, with EX->ID forwarding for
// branch-condition evaluation, a sticky overflow bit and a one-entry interrupt shadow.
module flag_register_unit #(
  parameter int unsigned         FLAGS_W   = 6,
  parameter logic [FLAGS_W-1:0]  RST_FLAGS = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [32:0]        alu_res_in,
  input  logic [4:0]         alu_flags_in,
  input  logic               ex_valid,
  input  logic               ex_flag_we,
  input  logic               stall,
  input  logic               flush,
  input  logic               cond_req,
  input  logic [2:0]         cond_sel,
  input  logic               cond_pol,
  input  logic               save,
  input  logic               restore,
  input  logic               clr_sticky,
  output logic [FLAGS_W-1:0] flags_q,
  output logic               ovf_sticky,
  output logic               cond_valid,
  output logic               cond_taken
);

  logic [FLAGS_W-1:0] shadow;
  logic [FLAGS_W-1:0] new_flags;
  logic [FLAGS_W-1:0] eff_commit;
  logic [FLAGS_W-1:0] eff;
  logic               wr;
  logic               act;
  logic               flag_sel;
  logic               taken;
  logic               unused_res;

  assign unused_res = ^alu_res_in[31:0];

  assign wr         = ex_valid & ex_flag_we & ~flush & ~stall;
  // flush overrides stall, so save/restore still act while flushing
  assign act        = flush | ~stall;
  assign new_flags  = {alu_res_in[32], alu_flags_in};
  assign eff_commit = wr ? new_flags : flags_q;
  assign eff        = restore ? shadow : eff_commit;

  always_comb begin
    flag_sel = 1'b0;
    unique case (cond_sel)
      3'd0:    flag_sel = eff[0];
      3'd1:    flag_sel = eff[1];
      3'd2:    flag_sel = eff[2];
      3'd3:    flag_sel = eff[3];
      3'd4:    flag_sel = eff[4];
      3'd5:    flag_sel = eff[5];
      3'd6:    flag_sel = 1'b1;
      default: flag_sel = 1'b0;
    endcase
    taken = cond_pol ? flag_sel : ~flag_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RST_FLAGS;
      shadow  <= RST_FLAGS;
    end else begin
      if (act && restore)
        flags_q <= shadow;
      else if (wr)
        flags_q <= new_flags;
      if (act && save)
        shadow <= eff_commit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_sticky <= 1'b0;
    else
      ovf_sticky <= (ovf_sticky | (wr & alu_flags_in[3])) & ~clr_sticky;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_valid <= 1'b0;
      cond_taken <= 1'b0;
    end else if (flush) begin
      cond_valid <= 1'b0;
    end else if (!stall) begin
      cond_valid <= cond_req;
      if (cond_req)
        cond_taken <= taken;
    end
  end

endmodule

// File: tb/tb_flag_register_unit.sv
// Scoreboard bench for flag_register_unit: a behavioural model pushes the expected
// post-edge state each cycle; every scenario task pops and compares inline.
module tb_flag_register_unit;

  logic        clk;
  logic        rst_n;
  logic [32:0] alu_res_in;
  logic [4:0]  alu_flags_in;
  logic        ex_valid, ex_flag_we, stall, flush;
  logic        cond_req, cond_pol, save, restore, clr_sticky;
  logic [2:0]  cond_sel;
  logic [5:0]  flags_q;
  logic        ovf_sticky, cond_valid, cond_taken;

  flag_register_unit #(.FLAGS_W(6), .RST_FLAGS(6'b000000)) dut (
    .clk(clk), .rst_n(rst_n), .alu_res_in(alu_res_in), .alu_flags_in(alu_flags_in),
    .ex_valid(ex_valid), .ex_flag_we(ex_flag_we), .stall(stall), .flush(flush),
    .cond_req(cond_req), .cond_sel(cond_sel), .cond_pol(cond_pol), .save(save),
    .restore(restore), .clr_sticky(clr_sticky), .flags_q(flags_q),
    .ovf_sticky(ovf_sticky), .cond_valid(cond_valid), .cond_taken(cond_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // expected record: {flags[5:0], sticky, cond_valid, cond_taken}
  logic [8:0] sb[$];
  logic [8:0] exp_rec;

  logic [5:0] m_flags, m_shadow;
  logic       m_sticky, m_cv, m_ct;

  function automatic logic [8:0] obs();
    return {flags_q, ovf_sticky, cond_valid, cond_taken};
  endfunction

  task automatic model_reset();
    m_flags = 6'h00; m_shadow = 6'h00; m_sticky = 1'b0; m_cv = 1'b0; m_ct = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_res_in = '0; alu_flags_in = '0; ex_valid = 0; ex_flag_we = 0; stall = 0; flush = 0;
    cond_req = 0; cond_sel = '0; cond_pol = 0; save = 0; restore = 0; clr_sticky = 0;
  endtask

  task automatic set_write(input logic [5:0] v);
    ex_valid = 1; ex_flag_we = 1;
    alu_res_in = {v[5], 32'h0000_0000};
    alu_flags_in = v[4:0];
  endtask

  // Predict the state after the coming edge, queue it, then advance to #1 past that edge.
  task automatic tick();
    logic [5:0] nf, base, eff, n_flags, n_shadow;
    logic       wr, act, f, n_sticky, n_cv, n_ct;
    nf   = {alu_res_in[32], alu_flags_in};
    wr   = ex_valid && ex_flag_we && !flush && !stall;
    act  = flush || !stall;
    base = wr ? nf : m_flags;
    eff  = restore ? m_shadow : base;
    if (cond_sel == 3'd6)      f = 1'b1;
    else if (cond_sel == 3'd7) f = 1'b0;
    else                       f = eff[cond_sel];
    n_flags = m_flags;
    if (act && restore) n_flags = m_shadow;
    else if (wr)        n_flags = nf;
    n_shadow = (act && save) ? base : m_shadow;
    n_sticky = clr_sticky ? 1'b0 : (m_sticky || (wr && alu_flags_in[3]));
    if (flush)       n_cv = 1'b0;
    else if (stall)  n_cv = m_cv;
    else             n_cv = cond_req;
    n_ct = (!flush && !stall && cond_req) ? (cond_pol ? f : !f) : m_ct;
    sb.push_back({n_flags, n_sticky, n_cv, n_ct});
    m_flags = n_flags; m_shadow = n_shadow; m_sticky = n_sticky; m_cv = n_cv; m_ct = n_ct;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12 rst_n = 1;
    nvec++;
    if (obs() !== 9'h000) begin
      nerr++; $display("FAIL reset_initial: got %h expected %h", obs(), 9'h000);
    end
    set_write(6'h3F); cond_req = 1; cond_sel = 3'd1; cond_pol = 1;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec) begin
      nerr++; $display("FAIL reset_prefill: got %h expected %h", obs(), exp_rec);
    end
    idle_inputs();
    cond_req = 1; cond_sel = 3'd1; cond_pol = 0;
    #2 rst_n = 0;
    #1;
    nvec++;
    if (obs() !== 9'h000) begin
      nerr++; $display("FAIL reset_async: got %h expected %h", obs(), 9'h000);
    end
    model_reset();
    #3 rst_n = 1;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec) begin
      nerr++; $display("FAIL reset_first_req: got %h expected %h", obs(), exp_rec);
    end
    nvec++;
    if ({cond_valid, cond_taken} !== 2'b11) begin
      nerr++; $display("FAIL reset_jf_true: got %b expected %b", {cond_valid, cond_taken}, 2'b11);
    end
    idle_inputs();
  endtask

  task automatic test_forward();
    idle_inputs();
    ex_valid = 1; ex_flag_we = 1; alu_res_in = 33'h0_0000_0000; alu_flags_in = 5'b10001;
    cond_req = 1; cond_sel = 3'd0; cond_pol = 1;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec) begin
      nerr++; $display("FAIL forward: got %h expected %h", obs(), exp_rec);
    end
    nvec++;
    if ({flags_q, cond_valid, cond_taken} !== {6'b010001, 2'b11}) begin
      nerr++; $display("FAIL forward_const: got %h expected %h", {flags_q, cond_valid, cond_taken}, {6'b010001, 2'b11});
    end
    idle_inputs();
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec) begin
      nerr++; $display("FAIL forward_drop_valid: got %h expected %h", obs(), exp_rec);
    end
  endtask

  task automatic test_carry_ovf();
    idle_inputs();
    ex_valid = 1; ex_flag_we = 1; alu_res_in = 33'h1_0000_0000; alu_flags_in = 5'b11001;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || flags_q !== 6'b111001 || ovf_sticky !== 1'b1) begin
      nerr++; $display("FAIL carry_ovf: got %h expected %h (flags 111001 sticky 1)", obs(), exp_rec);
    end
    set_write(6'h08); clr_sticky = 1;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || ovf_sticky !== 1'b0) begin
      nerr++; $display("FAIL sticky_clr_wins: got %h expected %h", obs(), exp_rec);
    end
    set_write(6'h08);
    tick();
    clr_sticky = 1; stall = 1; ex_valid = 0;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || ovf_sticky !== 1'b0) begin
      nerr++; $display("FAIL sticky_clr_in_stall: got %h expected %h", obs(), exp_rec);
    end
    idle_inputs();
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    set_write(6'h05); cond_req = 1; cond_sel = 3'd2; cond_pol = 1;
    tick();
    void'(sb.pop_front());
    stall = 1; set_write(6'h3A); cond_sel = 3'd0; cond_pol = 0;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || flags_q !== 6'h05 || {cond_valid, cond_taken} !== 2'b11) begin
      nerr++; $display("FAIL stall_hold: got %h expected %h", obs(), exp_rec);
    end
    flush = 1;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || flags_q !== 6'h05 || cond_valid !== 1'b0) begin
      nerr++; $display("FAIL flush_over_stall: got %h expected %h", obs(), exp_rec);
    end
    idle_inputs();
  endtask

  task automatic test_shadow();
    idle_inputs();
    set_write(6'h21);
    tick();
    idle_inputs(); save = 1;
    tick();
    idle_inputs(); set_write(6'h04);
    tick();
    void'(sb.pop_front()); void'(sb.pop_front());
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || flags_q !== 6'h04) begin
      nerr++; $display("FAIL shadow_write: got %h expected %h", obs(), exp_rec);
    end
    set_write(6'h3F); restore = 1;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || flags_q !== 6'h21) begin
      nerr++; $display("FAIL restore_over_commit: got %h expected %h", obs(), exp_rec);
    end
    idle_inputs(); set_write(6'h0A);
    tick();
    void'(sb.pop_front());
    idle_inputs(); save = 1; restore = 1;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || flags_q !== 6'h21) begin
      nerr++; $display("FAIL swap_flags: got %h expected %h", obs(), exp_rec);
    end
    idle_inputs(); restore = 1;
    tick();
    exp_rec = sb.pop_front(); nvec++;
    if (obs() !== exp_rec || flags_q !== 6'h0A) begin
      nerr++; $display("FAIL swap_shadow: got %h expected %h", obs(), exp_rec);
    end
    idle_inputs();
  endtask

  task automatic test_cond_exhaustive();
    for (int unsigned s = 0; s < 8; s++) begin
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned r = 0; r < 4; r++) begin
          idle_inputs();
          ex_valid = $urandom_range(0, 1); ex_flag_we = $urandom_range(0, 1);
          alu_res_in = {1'($urandom_range(0, 1)), 32'($urandom)};
          alu_flags_in = 5'($urandom);
          restore = ($urandom_range(0, 3) == 0);
          save = ($urandom_range(0, 3) == 0);
          cond_req = 1; cond_sel = 3'(s); cond_pol = 1'(p);
          tick();
          exp_rec = sb.pop_front(); nvec++;
          if (obs() !== exp_rec) begin
            nerr++; $display("FAIL cond sel=%0d pol=%0d: got %h expected %h", s, p, obs(), exp_rec);
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int unsigned i = 0; i < 300; i++) begin
      ex_valid = $urandom_range(0, 3) != 0; ex_flag_we = $urandom_range(0, 3) != 0;
      alu_res_in = {1'($urandom_range(0, 1)), 32'($urandom)};
      alu_flags_in = 5'($urandom);
      stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 6) == 0);
      cond_req = $urandom_range(0, 1); cond_sel = 3'($urandom); cond_pol = $urandom_range(0, 1);
      save = ($urandom_range(0, 5) == 0); restore = ($urandom_range(0, 5) == 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      tick();
      exp_rec = sb.pop_front(); nvec++;
      if (obs() !== exp_rec) begin
        nerr++; $display("FAIL random cycle %0d: got %h expected %h", i, obs(), exp_rec);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_carry_ovf();
    test_stall_flush();
    test_shadow();
    test_cond_exhaustive();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
